// File: rtl/gate_truth_table_checker_if.sv
// Bundles the checker's control/status handshake and the stimulus/response pins that
// connect it to the 2-input gate under test.
//   start      : request a new self-test run (host -> checker)
//   dut_y      : gate-under-test output (gate -> checker)
//   dut_a/b    : registered stimulus for gate inputs a and b (checker -> gate)
//   busy       : run in progress, including the DONE cycle
//   done       : single-cycle end-of-run pulse
//   pass       : every vector matched the expected truth table
//   fail_mask  : per-vector mismatch flags, bit k = vector {a,b}=k
//   captured   : raw sampled gate output, bit k = vector {a,b}=k
interface gate_truth_table_checker_if;
    logic       start;
    logic       dut_y;
    logic       dut_a;
    logic       dut_b;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] fail_mask;
    logic [3:0] captured;

    // Host side: owns start and (in a bench) the gate model driving dut_y.
    modport master (
        output start,
        output dut_y,
        input  dut_a,
        input  dut_b,
        input  busy,
        input  done,
        input  pass,
        input  fail_mask,
        input  captured
    );

    // Checker side.
    modport slave (
        input  start,
        input  dut_y,
        output dut_a,
        output dut_b,
        output busy,
        output done,
        output pass,
        output fail_mask,
        output captured
    );
endinterface

// File: rtl/gate_truth_table_checker.sv
// Hardware self-test engine for a 2-input combinational gate. Walks {a,b} through
// 00, 01, 10, 11, holds each vector for SETTLE_CYCLES clocks, samples the gate output
// in a one-cycle SAMPLE state and compares it against the EXPECTED truth table.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of gate_truth_table_checker_if (start/dut_y in; stimulus,
//           busy/done/pass and per-vector result vectors out)
// Parameters:
//   EXPECTED      : expected gate output, bit index = {a,b} (default AND)
//   SETTLE_CYCLES : hold time per vector before sampling, legal 1..255
//   CNT_W         : settle counter width, 2**CNT_W must exceed SETTLE_CYCLES
module gate_truth_table_checker #(
    parameter logic [3:0]  EXPECTED      = 4'b1000,
    parameter int unsigned SETTLE_CYCLES = 10,
    parameter int unsigned CNT_W         = 8
) (
    input logic                       clk,
    input logic                       rst_n,
    gate_truth_table_checker_if.slave bus
);

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StSample,
        StDone
    } state_e;

    // Count value on which SETTLE hands over to SAMPLE; SETTLE plus the SAMPLE cycle
    // then spans exactly SETTLE_CYCLES + 1 edges per vector.
    localparam logic [CNT_W-1:0] SettleLast = CNT_W'(SETTLE_CYCLES - 1);

    state_e           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             a_q, a_d;
    logic             b_q, b_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [3:0]       fail_mask_q, fail_mask_d;
    logic [3:0]       captured_q, captured_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            idx_q       <= 2'd0;
            cnt_q       <= '0;
            a_q         <= 1'b0;
            b_q         <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_mask_q <= 4'd0;
            captured_q  <= 4'd0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_mask_q <= fail_mask_d;
            captured_q  <= captured_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        busy_d      = busy_q;
        done_d      = done_q;
        pass_d      = pass_q;
        fail_mask_d = fail_mask_q;
        captured_d  = captured_q;

        unique case (state_q)
            StIdle: begin
                // Previous results stay visible here until a new run is accepted.
                if (bus.start) begin
                    idx_d       = 2'd0;
                    a_d         = 1'b0;
                    b_d         = 1'b0;
                    captured_d  = 4'd0;
                    fail_mask_d = 4'd0;
                    pass_d      = 1'b0;
                    cnt_d       = '0;
                    busy_d      = 1'b1;
                    state_d     = StSettle;
                end
            end

            StSettle: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == SettleLast) begin
                    state_d = StSample;
                end
            end

            StSample: begin
                captured_d[idx_q]  = bus.dut_y;
                fail_mask_d[idx_q] = (bus.dut_y != EXPECTED[idx_q]);
                if (idx_q != 2'd3) begin
                    idx_d      = idx_q + 2'd1;
                    {a_d, b_d} = idx_q + 2'd1;
                    cnt_d      = '0;
                    state_d    = StSettle;
                end else begin
                    // Verdict must include the vector-3 compare made on this same edge.
                    pass_d  = (fail_mask_d == 4'd0);
                    done_d  = 1'b1;
                    a_d     = 1'b0;
                    b_d     = 1'b0;
                    state_d = StDone;
                end
            end

            StDone: begin
                done_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign bus.dut_a     = a_q;
    assign bus.dut_b     = b_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.fail_mask = fail_mask_q;
    assign bus.captured  = captured_q;

endmodule

// File: tb/tb_gate_truth_table_checker.sv
// Bench for gate_truth_table_checker. Three checker instances (AND expectation with
// S=10, XOR expectation with S=10, AND expectation with S=1) each sit beside a gate
// model whose truth table the bench chooses; expected results come from the gate
// function and the documented timing.
module tb_gate_truth_table_checker;

    localparam int GAnd  = 0;
    localparam int GOr   = 1;
    localparam int GXor  = 2;
    localparam int GZero = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [2:0] start;
    logic [2:0] glitch;
    logic [3:0] tt [3];
    logic [2:0] a_o, b_o, busy_o, done_o, pass_o;
    logic [3:0] cap_o [3];
    logic [3:0] fm_o [3];
    int         settle [3];
    logic [3:0] expv [3];

    gate_truth_table_checker_if if0 ();
    gate_truth_table_checker_if if1 ();
    gate_truth_table_checker_if if2 ();

    gate_truth_table_checker #(.EXPECTED(4'b1000), .SETTLE_CYCLES(10), .CNT_W(8)) u_dut0 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (if0)
    );
    gate_truth_table_checker #(.EXPECTED(4'b0110), .SETTLE_CYCLES(10), .CNT_W(8)) u_dut1 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (if1)
    );
    gate_truth_table_checker #(.EXPECTED(4'b1000), .SETTLE_CYCLES(1), .CNT_W(8)) u_dut2 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (if2)
    );

    // Gate models: output = truth table entry for the current stimulus, optionally
    // disturbed by glitches outside the sampling cycle.
    assign if0.start = start[0];
    assign if1.start = start[1];
    assign if2.start = start[2];
    assign if0.dut_y = tt[0][{if0.dut_a, if0.dut_b}] ^ glitch[0];
    assign if1.dut_y = tt[1][{if1.dut_a, if1.dut_b}] ^ glitch[1];
    assign if2.dut_y = tt[2][{if2.dut_a, if2.dut_b}] ^ glitch[2];

    assign a_o    = {if2.dut_a, if1.dut_a, if0.dut_a};
    assign b_o    = {if2.dut_b, if1.dut_b, if0.dut_b};
    assign busy_o = {if2.busy, if1.busy, if0.busy};
    assign done_o = {if2.done, if1.done, if0.done};
    assign pass_o = {if2.pass, if1.pass, if0.pass};
    assign cap_o[0] = if0.captured;
    assign cap_o[1] = if1.captured;
    assign cap_o[2] = if2.captured;
    assign fm_o[0]  = if0.fail_mask;
    assign fm_o[1]  = if1.fail_mask;
    assign fm_o[2]  = if2.fail_mask;

    // Truth table of a named gate, bit index = {a,b}.
    function automatic logic [3:0] build_tt(input int kind);
        logic [3:0] t;
        int         a;
        int         b;
        for (int v = 0; v < 4; v++) begin
            a = v / 2;
            b = v % 2;
            case (kind)
                GAnd:    t[v] = (a * b) != 0;
                GOr:     t[v] = (a + b) != 0;
                GXor:    t[v] = (a + b) == 1;
                default: t[v] = 1'b0;
            endcase
        end
        return t;
    endfunction

    // Per-vector mismatch between what the gate produces and what was expected.
    function automatic logic [3:0] model_fail(input logic [3:0] t, input logic [3:0] e);
        logic [3:0] m;
        for (int k = 0; k < 4; k++) m[k] = (t[k] != e[k]);
        return m;
    endfunction

    // Launches one run on instance sel and follows it for a bounded number of edges.
    // n counts edges after the accept edge E0; observations are taken #1 after each edge.
    task automatic do_run(input int sel, input bit glitch_en, input int rp1, input int rp2,
                          output int done_at, output int done_cnt, output int stim_bad,
                          output int busy_bad);
        int s;
        int lim;
        int exp_vec;
        s        = settle[sel];
        lim      = 4 * (s + 1);
        done_at  = -1;
        done_cnt = 0;
        stim_bad = 0;
        busy_bad = 0;
        @(negedge clk);
        start[sel] = 1'b1;
        @(posedge clk);
        #1;
        start[sel] = 1'b0;
        for (int n = 0; n <= lim + 3; n++) begin
            if (n > 0) begin
                @(posedge clk);
                #1;
            end
            exp_vec = (n < lim) ? n / (s + 1) : 0;
            if ({a_o[sel], b_o[sel]} !== exp_vec[1:0]) stim_bad++;
            if (busy_o[sel] !== logic'(n <= lim)) busy_bad++;
            if (done_o[sel] === 1'b1) begin
                done_cnt++;
                if (done_at < 0) done_at = n;
            end
            start[sel] = logic'((n + 1 == rp1) || (n + 1 == rp2));
            // The cycle ending on a sample edge must stay clean.
            if (glitch_en && ((n + 1) % (s + 1) != 0)) glitch[sel] = 1'($urandom_range(0, 1));
            else glitch[sel] = 1'b0;
        end
        glitch[sel] = 1'b0;
        start[sel]  = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy_o, done_o, pass_o, a_o, b_o} !== 15'd0) begin
            errors++;
            $display("FAIL reset_scalars: got %b want 0", {busy_o, done_o, pass_o, a_o, b_o});
        end
        checks++;
        if ({cap_o[0], cap_o[1], cap_o[2], fm_o[0], fm_o[1], fm_o[2]} !== 24'd0) begin
            errors++;
            $display("FAIL reset_vectors: got %h want 0",
                     {cap_o[0], cap_o[1], cap_o[2], fm_o[0], fm_o[1], fm_o[2]});
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy_o, done_o, a_o, b_o} !== 12'd0) begin
            errors++;
            $display("FAIL idle_after_reset: got %b want 0", {busy_o, done_o, a_o, b_o});
        end
    endtask

    task automatic test_and;
        int d_at, d_cnt, s_bad, b_bad;
        tt[0] = build_tt(GAnd);
        do_run(0, 1'b0, -1, -1, d_at, d_cnt, s_bad, b_bad);
        checks++;
        if (d_at !== 44) begin
            errors++;
            $display("FAIL and_done_edge: got %0d want 44", d_at);
        end
        checks++;
        if (d_cnt !== 1) begin
            errors++;
            $display("FAIL and_done_pulses: got %0d want 1", d_cnt);
        end
        checks++;
        if (s_bad !== 0) begin
            errors++;
            $display("FAIL and_stimulus_seq: got %0d bad cycles want 0", s_bad);
        end
        checks++;
        if (b_bad !== 0) begin
            errors++;
            $display("FAIL and_busy_window: got %0d bad cycles want 0", b_bad);
        end
        checks++;
        if ({cap_o[0], fm_o[0], pass_o[0]} !== {tt[0], model_fail(tt[0], expv[0]), 1'b1}) begin
            errors++;
            $display("FAIL and_results: got cap=%b fm=%b pass=%b want cap=%b fm=0000 pass=1",
                     cap_o[0], fm_o[0], pass_o[0], tt[0]);
        end
    endtask

    task automatic test_or;
        int d_at, d_cnt, s_bad, b_bad;
        tt[0] = build_tt(GOr);
        do_run(0, 1'b0, -1, -1, d_at, d_cnt, s_bad, b_bad);
        checks++;
        if (cap_o[0] !== tt[0]) begin
            errors++;
            $display("FAIL or_captured: got %b want %b", cap_o[0], tt[0]);
        end
        checks++;
        if (fm_o[0] !== model_fail(tt[0], expv[0])) begin
            errors++;
            $display("FAIL or_fail_mask: got %b want %b", fm_o[0], model_fail(tt[0], expv[0]));
        end
        checks++;
        if (pass_o[0] !== 1'b0) begin
            errors++;
            $display("FAIL or_pass: got %b want 0", pass_o[0]);
        end
        // Results must persist through IDLE.
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if ({cap_o[0], fm_o[0]} !== {tt[0], model_fail(tt[0], expv[0])}) begin
            errors++;
            $display("FAIL or_hold_in_idle: got %b/%b want %b/%b", cap_o[0], fm_o[0], tt[0],
                     model_fail(tt[0], expv[0]));
        end
    endtask

    task automatic test_zero_and_xor;
        int d_at, d_cnt, s_bad, b_bad;
        tt[0] = build_tt(GZero);
        do_run(0, 1'b0, -1, -1, d_at, d_cnt, s_bad, b_bad);
        checks++;
        if ({cap_o[0], fm_o[0], pass_o[0]} !== {4'b0000, model_fail(tt[0], expv[0]), 1'b0}) begin
            errors++;
            $display("FAIL zero_results: got cap=%b fm=%b pass=%b want cap=0000 fm=%b pass=0",
                     cap_o[0], fm_o[0], pass_o[0], model_fail(tt[0], expv[0]));
        end
        tt[1] = build_tt(GXor);
        do_run(1, 1'b0, -1, -1, d_at, d_cnt, s_bad, b_bad);
        checks++;
        if ({d_at, cap_o[1], fm_o[1], pass_o[1]} !== {44, tt[1], 4'b0000, 1'b1}) begin
            errors++;
            $display("FAIL xor_results: got done@%0d cap=%b fm=%b pass=%b want done@44 cap=%b fm=0000 pass=1",
                     d_at, cap_o[1], fm_o[1], pass_o[1], tt[1]);
        end
    endtask

    task automatic test_start_while_busy;
        int d_at, d_cnt, s_bad, b_bad;
        tt[0] = build_tt(GAnd);
        do_run(0, 1'b0, 5, 30, d_at, d_cnt, s_bad, b_bad);
        checks++;
        if ({d_at, d_cnt, s_bad} !== {44, 1, 0}) begin
            errors++;
            $display("FAIL busy_start_ignored: got done@%0d pulses=%0d stim_bad=%0d want 44/1/0",
                     d_at, d_cnt, s_bad);
        end
        checks++;
        if ({cap_o[0], fm_o[0], pass_o[0]} !== {tt[0], 4'b0000, 1'b1}) begin
            errors++;
            $display("FAIL busy_start_results: got %b/%b/%b want %b/0000/1", cap_o[0], fm_o[0],
                     pass_o[0], tt[0]);
        end
    endtask

    task automatic test_reset_mid_run;
        int d_at, d_cnt, s_bad, b_bad;
        int bad;
        tt[0] = build_tt(GAnd);
        @(negedge clk);
        start[0] = 1'b1;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        checks++;
        if ({busy_o[0], a_o[0], b_o[0]} !== 3'b101) begin
            errors++;
            $display("FAIL midrun_before_reset: got %b want 101", {busy_o[0], a_o[0], b_o[0]});
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy_o[0], done_o[0], pass_o[0], a_o[0], b_o[0], cap_o[0], fm_o[0]} !== 13'd0) begin
            errors++;
            $display("FAIL midrun_reset_clears: got %b want 0",
                     {busy_o[0], done_o[0], pass_o[0], a_o[0], b_o[0], cap_o[0], fm_o[0]});
        end
        bad = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (done_o[0] !== 1'b0 || busy_o[0] !== 1'b0) bad++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (50) begin
            @(posedge clk);
            #1;
            if (done_o[0] !== 1'b0 || busy_o[0] !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL midrun_no_done: got %0d bad cycles want 0", bad);
        end
        do_run(0, 1'b0, -1, -1, d_at, d_cnt, s_bad, b_bad);
        checks++;
        if ({d_at, pass_o[0], cap_o[0]} !== {44, 1'b1, tt[0]}) begin
            errors++;
            $display("FAIL midrun_fresh_run: got done@%0d pass=%b cap=%b want 44/1/%b", d_at,
                     pass_o[0], cap_o[0], tt[0]);
        end
    endtask

    task automatic test_back_to_back;
        int         first_done, second_done, done_cnt, busy_low, busy_low_at;
        logic [5:0] res9;
        logic [9:0] res10;
        tt[2] = build_tt(GAnd);
        first_done  = -1;
        second_done = -1;
        done_cnt    = 0;
        busy_low    = 0;
        busy_low_at = -1;
        res9        = '0;
        res10       = '1;
        @(negedge clk);
        start[2] = 1'b1;
        @(posedge clk);
        #1;
        for (int n = 1; n <= 30; n++) begin
            @(posedge clk);
            #1;
            if (done_o[2] === 1'b1) begin
                done_cnt++;
                if (first_done < 0) first_done = n;
                else if (second_done < 0) second_done = n;
            end
            if (n <= 17 && busy_o[2] !== 1'b1) begin
                busy_low++;
                busy_low_at = n;
            end
            if (n == 9) res9 = {pass_o[2], busy_o[2], cap_o[2]};
            if (n == 10) begin
                res10    = {pass_o[2], busy_o[2], cap_o[2], fm_o[2]};
                start[2] = 1'b0;
            end
        end
        checks++;
        if ({first_done, second_done, done_cnt} !== {8, 18, 2}) begin
            errors++;
            $display("FAIL b2b_done_edges: got %0d/%0d/%0d want 8/18/2", first_done, second_done,
                     done_cnt);
        end
        checks++;
        if ({busy_low, busy_low_at} !== {1, 9}) begin
            errors++;
            $display("FAIL b2b_busy_gap: got %0d low cycles at %0d want 1 at 9", busy_low,
                     busy_low_at);
        end
        checks++;
        if (res9 !== {1'b1, 1'b0, tt[2]}) begin
            errors++;
            $display("FAIL b2b_first_results: got %b want %b", res9, {1'b1, 1'b0, tt[2]});
        end
        checks++;
        if (res10 !== 10'b01_0000_0000) begin
            errors++;
            $display("FAIL b2b_cleared_on_accept: got %b want 0100000000", res10);
        end
        checks++;
        if ({pass_o[2], busy_o[2], cap_o[2]} !== {1'b1, 1'b0, tt[2]}) begin
            errors++;
            $display("FAIL b2b_second_results: got %b want %b", {pass_o[2], busy_o[2], cap_o[2]},
                     {1'b1, 1'b0, tt[2]});
        end
    endtask

    task automatic test_random;
        int         d_at, d_cnt, s_bad, b_bad, sel;
        logic [3:0] fm_exp;
        for (int i = 0; i < 9; i++) begin
            sel     = i % 3;
            tt[sel] = 4'($urandom_range(0, 15));
            fm_exp  = model_fail(tt[sel], expv[sel]);
            do_run(sel, 1'b1, -1, -1, d_at, d_cnt, s_bad, b_bad);
            checks++;
            if ({d_at, d_cnt, s_bad, b_bad} !== {4 * (settle[sel] + 1), 1, 0, 0}) begin
                errors++;
                $display("FAIL rand_timing[%0d]: got done@%0d pulses=%0d stim_bad=%0d busy_bad=%0d want done@%0d 1 0 0",
                         i, d_at, d_cnt, s_bad, b_bad, 4 * (settle[sel] + 1));
            end
            checks++;
            if ({cap_o[sel], fm_o[sel], pass_o[sel]} !== {tt[sel], fm_exp, logic'(fm_exp == 0)})
            begin
                errors++;
                $display("FAIL rand_results[%0d]: got cap=%b fm=%b pass=%b want cap=%b fm=%b pass=%b",
                         i, cap_o[sel], fm_o[sel], pass_o[sel], tt[sel], fm_exp, fm_exp == 0);
            end
        end
    endtask

    initial begin
        start     = 3'b000;
        glitch    = 3'b000;
        tt[0]     = 4'd0;
        tt[1]     = 4'd0;
        tt[2]     = 4'd0;
        settle[0] = 10;
        settle[1] = 10;
        settle[2] = 1;
        expv[0]   = 4'b1000;
        expv[1]   = 4'b0110;
        expv[2]   = 4'b1000;

        test_reset();
        test_and();
        test_or();
        test_zero_and_xor();
        test_start_while_busy();
        test_reset_mid_run();
        test_back_to_back();
        test_random();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
